// File: rtl/cbus_burst_ram.sv
// CBus burst memory slave: single/burst reads and writes into a 64-bit RAM
// with a programmable first-beat latency. Request/response structs live in
// the package below so masters and benches share one definition.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_burst_ram
  import cbus_pkg::*;
#(
  parameter int ADDR_BITS    = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  req,
  output cbus_resp_t resp
);

  typedef enum logic [1:0] {IDLE, LAT, XFER, DONE} state_t;

  localparam logic [3:0] LAT_INIT = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;

  state_t               r_state;
  logic                 r_is_write;
  logic                 r_fixed;
  logic [7:0]           r_len;
  logic [7:0]           r_cnt;
  logic [3:0]           r_lat;
  logic [ADDR_BITS-1:0] r_idx;
  logic [63:0]          r_mem [2**ADDR_BITS];

  logic w_beat;
  logic w_unused;

  // A beat happens only while the master keeps valid up; a dropped valid is an abort.
  assign w_beat   = (r_state == XFER) && req.valid;
  // Upper/lower address bits and size are deliberately ignored (aliasing).
  assign w_unused = ^{req.size, req.addr[63:ADDR_BITS+3], req.addr[2:0]};

  // Transaction FSM: capture the request in IDLE, count latency, stream beats.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_is_write <= 1'b0;
      r_fixed    <= 1'b0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_lat      <= '0;
      r_idx      <= '0;
    end else begin
      case (r_state)
        IDLE: if (req.valid) begin
          r_is_write <= req.is_write;
          r_len      <= req.len;
          r_fixed    <= (req.burst == 2'd0);  // 2 and 3 behave as INCR
          r_idx      <= req.addr[ADDR_BITS+2:3];
          r_cnt      <= '0;
          if (READ_LATENCY > 0) begin
            r_state <= LAT;
            r_lat   <= LAT_INIT;
          end else begin
            r_state <= XFER;
          end
        end
        LAT: begin
          if (!req.valid)       r_state <= IDLE;
          else if (r_lat == '0) r_state <= XFER;
          else                  r_lat   <= r_lat - 4'd1;
        end
        XFER: begin
          if (!req.valid) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (!r_fixed) r_idx <= r_idx + 1'b1;  // wraps at top of memory
            if (r_cnt == r_len) r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;  // bubble so the master can drop valid
        default: r_state <= IDLE;
      endcase
    end
  end

  // Byte-strobed write port; memory itself is never reset and the reset edge never writes.
  always_ff @(posedge clk) begin
    if (reset && w_beat && r_is_write) begin
      for (int b = 0; b < 8; b++) begin
        if (req.strobe[b]) r_mem[r_idx][8*b +: 8] <= req.data[8*b +: 8];
      end
    end
  end

  // Response: ready qualified by valid, data read asynchronously from the current index.
  always_comb begin
    resp       = '0;
    resp.ready = w_beat;
    resp.last  = w_beat && (r_cnt == r_len);
    if (r_state == XFER) resp.data = r_mem[r_idx];
  end

  logic w_unused_wr;
  assign w_unused_wr = r_is_write & w_unused;

endmodule

// File: tb/tb_cbus_burst_ram.sv
// Scoreboard bench for cbus_burst_ram: expected beats are queued when a
// transaction is launched and popped as the DUT raises ready. A shadow
// memory tracks committed writes. Two instances: latency 2 and latency 0.
module tb_cbus_burst_ram;
  import cbus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  int         sel;
  cbus_req_t  req, req0, req1;
  cbus_resp_t resp, resp0, resp1;

  always #5 clk = ~clk;

  // Route the shared request to the selected instance only.
  always_comb begin
    req0       = req;
    req1       = req;
    req0.valid = req.valid && (sel == 0);
    req1.valid = req.valid && (sel == 1);
    resp       = (sel == 1) ? resp1 : resp0;
  end

  cbus_burst_ram #(.ADDR_BITS(4), .READ_LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req(req0), .resp(resp0)
  );

  cbus_burst_ram #(.ADDR_BITS(4), .READ_LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req1), .resp(resp1)
  );

  typedef struct {
    logic [63:0] d;
    logic        last;
    logic        chk_d;
  } exp_t;

  exp_t        q[$];
  logic [63:0] shadow [2][16];
  logic [63:0] wd [16];
  logic [7:0]  st [16];
  logic [63:0] rd_log [16];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // mode 0: normal, 1: drop valid after k beats, 2: reset during beat k
  task automatic run_txn(input logic wr, input logic [63:0] addr, input int len,
                         input logic [1:0] burst, input int mode, input int k);
    int   rl, ri, widx, beat, cyc;
    exp_t e;
    rl = (sel == 1) ? 0 : 2;
    ri = int'(addr[6:3]);
    for (int b = 0; b <= len; b++) begin
      e.d     = wr ? 64'd0 : shadow[sel][ri];
      e.last  = (b == len);
      e.chk_d = !wr;
      q.push_back(e);
      if (burst != 2'd0) ri = (ri + 1) % 16;
    end
    @(negedge clk);
    req.valid    = 1'b1;
    req.is_write = wr;
    req.size     = 3'd3;
    req.addr     = addr;
    req.len      = 8'(len);
    req.burst    = burst;
    req.data     = wd[0];
    req.strobe   = st[0];
    widx = int'(addr[6:3]);
    beat = 0;
    cyc  = 0;
    while (1) begin
      #1;
      if (resp.ready) begin
        if (beat == 0) chk("first_beat_lat", 64'(cyc), 64'(rl + 1));
        if (q.size() == 0) begin
          chk("extra_beat", 64'(beat), 64'(len + 1));
          break;
        end
        e = q.pop_front();
        chk("last", 64'(resp.last), 64'(e.last));
        if (e.chk_d) chk("rdata", resp.data, e.d);
        else begin
          for (int b = 0; b < 8; b++)
            if (req.strobe[b]) shadow[sel][widx][8*b +: 8] = req.data[8*b +: 8];
        end
        rd_log[beat] = resp.data;
        if (burst != 2'd0) widx = (widx + 1) % 16;
        beat++;
        if (e.last) begin
          @(negedge clk);
          req.valid = 1'b0;
          #1;
          chk("done_ready", 64'(resp.ready), 64'd0);
          break;
        end
      end
      cyc++;
      if (cyc > 40) begin
        chk("timeout", 64'(cyc), 64'd0);
        break;
      end
      @(negedge clk);
      if (mode == 1 && beat == k) begin
        req.valid = 1'b0;
        #1;
        chk("abort_ready", 64'(resp.ready), 64'd0);
        break;
      end
      if (mode == 2 && beat == k) begin
        reset = 1'b0;
        @(negedge clk);
        reset     = 1'b1;
        req.valid = 1'b0;
        #1;
        chk("rst_ready", 64'(resp.ready), 64'd0);
        chk("rst_last", 64'(resp.last), 64'd0);
        chk("rst_data", resp.data, 64'd0);
        break;
      end
      req.data   = wd[beat];
      req.strobe = st[beat];
    end
    q.delete();
  endtask

  initial begin
    sel   = 0;
    req   = '0;
    reset = 1'b0;
    foreach (st[i]) st[i] = 8'hFF;
    foreach (wd[i]) wd[i] = 64'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", 64'(resp.ready), 64'd0);
    chk("reset_last", 64'(resp.last), 64'd0);
    chk("reset_data", resp.data, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // single write then read, aliased address 0x80000008 -> word 1
    wd[0] = 64'h1122334455667788;
    run_txn(1'b1, 64'h80000008, 0, 2'd1, 0, 0);
    run_txn(1'b0, 64'h80000008, 0, 2'd1, 0, 0);
    chk("single_rd", rd_log[0], 64'h1122334455667788);

    // preload words 0..15 with i via a 16-beat INCR write, then read back
    foreach (wd[i]) wd[i] = 64'(i);
    run_txn(1'b1, 64'h0, 15, 2'd1, 0, 0);
    run_txn(1'b0, 64'h0, 15, 2'd1, 0, 0);
    chk("incr16_beat15", rd_log[15], 64'd15);

    // wrap at top of memory: words 14,15,0,1 (burst=3 behaves as INCR)
    run_txn(1'b0, 64'h70, 3, 2'd3, 0, 0);
    chk("wrap0", rd_log[0], 64'd14);
    chk("wrap1", rd_log[1], 64'd15);
    chk("wrap2", rd_log[2], 64'd0);
    chk("wrap3", rd_log[3], 64'd1);

    // strobed FIXED burst into word 8 (cleared first)
    wd[0] = 64'd0;
    run_txn(1'b1, 64'h40, 0, 2'd1, 0, 0);
    foreach (wd[i]) wd[i] = 64'hAAAAAAAAAAAAAAAA;
    st[0] = 8'h01; st[1] = 8'h02; st[2] = 8'h04; st[3] = 8'h08;
    run_txn(1'b1, 64'h40, 3, 2'd0, 0, 0);
    foreach (st[i]) st[i] = 8'hFF;
    run_txn(1'b0, 64'h40, 0, 2'd1, 0, 0);
    chk("strobe_word8", rd_log[0], 64'h00000000AAAAAAAA);
    run_txn(1'b0, 64'h48, 0, 2'd1, 0, 0);
    chk("fixed_word9", rd_log[0], 64'd9);

    // abort an 8-beat write after 2 beats; next request in the following cycle
    foreach (wd[i]) wd[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    run_txn(1'b1, 64'h20, 7, 2'd1, 1, 2);
    run_txn(1'b0, 64'h20, 7, 2'd1, 0, 0);
    chk("abort_w4", rd_log[0], 64'hC0DE000000000000);
    chk("abort_w6", rd_log[2], 64'd6);

    // reset during beat 3 of a read; memory survives
    run_txn(1'b0, 64'h0, 7, 2'd1, 2, 3);
    run_txn(1'b0, 64'h0, 3, 2'd1, 0, 0);
    chk("post_rst_w2", rd_log[2], 64'd2);

    // zero-latency instance
    sel   = 1;
    wd[0] = 64'hDEADBEEF01234567;
    run_txn(1'b1, 64'h18, 0, 2'd1, 0, 0);
    run_txn(1'b0, 64'h18, 0, 2'd1, 0, 0);
    chk("lat0_rd", rd_log[0], 64'hDEADBEEF01234567);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop guard in case a task loop misbehaves.
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d want=0", 1);
    $fatal(1, "timeout");
  end

endmodule
